instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, program-address width in bits.
REQ-002 Parameter STACK_DEPTH, default 8, number of return-stack entries, which SHALL be a power of two and at least 2.
REQ-003 Clock  input  1  single rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 iStall  input  1  freeze request from downstream (e.g. LCD busy).
REQ-006 iBranchTaken  input  1  load PC from iTarget.
REQ-007 iCall  input  1  push return address and load PC from iTarget.
REQ-008 iRet  input  1  pop return stack into PC.
REQ-009 iTarget  input  ADDR_W  jump, branch or call destination.
REQ-010 iDelayStart  input  1  start busy-wait delay (NOP with operand).
REQ-011 iDelayCount  input  24  delay length in cycles.
REQ-012 oAddress  output  ADDR_W  registered PC, driven to ROM iAddress.
REQ-013 oBusy  output  1  high while in DELAY state.
REQ-014 oStackOverflow  output  1  sticky flag: a CALL was made while the stack was full.
REQ-015 oStackUnderflow  output  1  sticky flag: a RET was made while the stack was empty.

Function
REQ-016 oAddress SHALL be a register; a control input sampled on rising edge k SHALL be reflected on oAddress after edge k.
REQ-017 The block SHALL have two states, RUN and DELAY.
REQ-018 In RUN, the highest-priority active event SHALL be applied and all lower-priority events ignored, in this order: iStall, iDelayStart, iRet, iCall, iBranchTaken, increment.
REQ-019 iStall=1 SHALL hold the PC, the stack and the state unchanged.
REQ-020 iDelayStart with iDelayCount=N>0 SHALL load a down-counter with N-1, enter DELAY and hold the PC.
REQ-021 iDelayStart with N=0 SHALL act as increment.
REQ-022 In DELAY, the PC SHALL hold and oBusy SHALL be 1.
REQ-023 In DELAY, the counter SHALL decrement only when iStall=0; all other control inputs SHALL be ignored.
REQ-024 In DELAY, when the counter is 0 and iStall=0, the next edge SHALL set PC=PC+1 and return to RUN, so the total hold is N cycles.
REQ-025 iCall SHALL push PC+1, set PC=iTarget and increment the stack pointer.
REQ-026 iCall with the stack full (STACK_DEPTH entries) SHALL still set PC=iTarget, SHALL drop the push, SHALL leave the pointer unchanged and SHALL set oStackOverflow.
REQ-027 iRet SHALL set PC to the top entry and decrement the stack pointer.
REQ-028 iRet with the stack empty SHALL set PC=0 and SHALL set oStackUnderflow.
REQ-029 iCall and iRet asserted together SHALL be resolved by REQ-018: iRet wins and iCall is fully ignored, with no push.
REQ-030 iBranchTaken SHALL set PC=iTarget.
REQ-031 Increment SHALL set PC=PC+1 modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 with no flag.
REQ-032 Stack storage SHALL use no reset, but its contents SHALL be unobservable until written.
REQ-033 oStackOverflow and oStackUnderflow SHALL clear only on reset.

Reset
REQ-034 Reset low SHALL immediately, without a clock, force oAddress=0, stack pointer=0, state=RUN, delay counter=0, oBusy=0 and both flags=0.
REQ-035 Reset asserted mid-DELAY or mid-stall SHALL abort the operation.
REQ-036 After reset deasserts, the first rising edge with no control input active SHALL yield oAddress=1.

Verification
REQ-037 Release reset with no inputs for 5 cycles -> oAddress sequence 0,1,2,3,4,5.
REQ-038 At PC=3, pulse iCall with iTarget=7; at PC=10, pulse iRet -> oAddress sequence 3,7,…,10,4.
REQ-039 At PC=0, pulse iDelayStart with iDelayCount=4 and raise iStall for 2 cycles during DELAY -> oAddress held at 0 and oBusy=1 for 6 cycles, then oAddress=1 and oBusy=0.
REQ-040 Nine nested iCall with iTarget=0x20 and STACK_DEPTH=8 -> oStackOverflow=1 after the 9th; nine iRet -> first return is 0x21, the last 8 returns match pushes, and the 9th gives PC=0 with oStackUnderflow=1.
REQ-041 iCall, iRet and iBranchTaken all asserted with iStall=1 -> no change; drop iStall -> iRet applied only and the stack pointer decrements by 1.
REQ-042 PC=0xFFFF with no control input -> oAddress=0x0000; assert Reset asynchronously mid-cycle -> oAddress=0 before the next edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: registered program counter with a hardware return
// stack, a busy-wait delay state and a global stall.
//
// Control handshake: there is no valid/ready pairing here. Every control
// input is a level sampled on each rising Clock edge. iStall is the only
// back-pressure signal; while it is high nothing in the block advances.
// In RUN the event priority is: stall, delay start, return, call, branch,
// increment. Only the winning event takes effect.
//
// The FSM state is visible on oBusy (1 = DELAY, 0 = RUN).
module instruction_fetch #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic              iCall,
  input  logic              iRet,
  input  logic [ADDR_W-1:0] iTarget,
  input  logic              iDelayStart,
  input  logic [23:0]       iDelayCount,
  output logic [ADDR_W-1:0] oAddress,
  output logic              oBusy,
  output logic              oStackOverflow,
  output logic              oStackUnderflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  // The pointer has one extra bit so that "full" (== STACK_DEPTH) is representable.
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(STACK_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    DELAY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [PTR_W:0]    sp_q, sp_d;
  logic [23:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [PTR_W-1:0]  top_idx;

  // Return-stack storage. Entries at or above the pointer are never read,
  // so stale contents after reset cannot reach the PC.
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign top_idx = PTR_W'(sp_q - 1'b1);

  // Next-state logic: priority-resolved control in RUN, countdown in DELAY.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (state_q)
      RUN: begin
        if (iStall) begin
          // Hold everything.
        end else if (iDelayStart) begin
          if (iDelayCount != 24'd0) begin
            // Counter holds the remaining hold cycles after this one.
            cnt_d   = iDelayCount - 24'd1;
            state_d = DELAY;
          end else begin
            pc_d = pc_inc;
          end
        end else if (iRet) begin
          if (sp_q == '0) begin
            pc_d  = '0;
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - 1'b1;
          end
        end else if (iCall) begin
          pc_d = iTarget;
          if (sp_q == SP_FULL) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + 1'b1;
          end
        end else if (iBranchTaken) begin
          pc_d = iTarget;
        end else begin
          pc_d = pc_inc;
        end
      end
      DELAY: begin
        if (!iStall) begin
          if (cnt_q == 24'd0) begin
            pc_d    = pc_inc;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-stack write port; no reset on the storage itself.
  always_ff @(posedge Clock) begin
    if (push_en) begin
      stack_q[sp_q[PTR_W-1:0]] <= pc_inc;
    end
  end

  assign oAddress        = pc_q;
  assign oBusy           = (state_q == DELAY);
  assign oStackOverflow  = ovf_q;
  assign oStackUnderflow = unf_q;

endmodule
